// File: rtl/codebreaker_switch_pio.sv
// rtl/codebreaker_switch_pio.sv - Avalon-MM input PIO: sync, debounce, edge capture, masked irq
// Optional feature macro: CODEBREAKER_SWITCH_DEBOUNCE_EN (defined: per-bit debounce counters;
// undefined: debounced state follows the synchroniser output directly).
module codebreaker_switch_pio #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_edge_set;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr_mask;
    logic             w_wr_edge;
    logic [31:0]      w_rd;
    logic             w_unused;

    assign w_wdata   = writedata[WIDTH-1:0];
    assign w_wr_mask = chipselect & write & (address == 2'd1);
    assign w_wr_edge = chipselect & write & (address == 2'd3);
    assign w_clr     = w_wr_edge ? w_wdata : '0;

    // Two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef CODEBREAKER_SWITCH_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LP_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_cnt [WIDTH];

    // Per-bit debounce: accept a new level only after it has differed from the
    // accepted level for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_CNT_MAX) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_stable = r_stable;
    assign w_unused = &{1'b0, writedata};
`else
    logic [31:0] w_unused_db;

    assign w_stable    = r_sync2;
    assign w_unused_db = DEBOUNCE_CYCLES;
    assign w_unused    = &{1'b0, writedata, w_unused_db};
`endif

    // Qualifying edge of the debounced state against its one-cycle-old copy
    always_comb begin
        w_edge_set = '0;
        case (EDGE_MODE)
            1:       w_edge_set = ~w_stable & r_stable_d;
            2:       w_edge_set = w_stable ^ r_stable_d;
            default: w_edge_set = w_stable & ~r_stable_d;
        endcase
    end

    // Register readback mux, zero-extended to the bus width
    always_comb begin
        w_rd = '0;
        case (address)
            2'd0:    w_rd[WIDTH-1:0] = w_stable;
            2'd1:    w_rd[WIDTH-1:0] = r_mask;
            2'd2:    w_rd[WIDTH-1:0] = r_sync2;
            default: w_rd[WIDTH-1:0] = r_edge;
        endcase
    end

    // Delayed state, mask/edge registers, read data and interrupt; a new edge beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_d <= '0;
            r_mask     <= '0;
            r_edge     <= '0;
            readdata   <= '0;
            irq        <= 1'b0;
        end else begin
            r_stable_d <= w_stable;
            if (w_wr_mask) begin
                r_mask <= w_wdata;
            end
            r_edge   <= (r_edge & ~w_clr) | w_edge_set;
            readdata <= w_rd;
            irq      <= |(r_edge & r_mask);
        end
    end

endmodule

// File: tb/tb_codebreaker_switch_pio.sv
// tb/tb_codebreaker_switch_pio.sv - directed plus randomized bench with a window-based reference model
module tb_codebreaker_switch_pio;

    localparam int W = 10;
    localparam int N = 4;
`ifdef CODEBREAKER_SWITCH_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif
    localparam int LAT = DB_ON ? N + 2 : 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_vec = 0;
    int n_fail = 0;

    logic [W-1:0] pin_v;

    // reference model state (value after the most recent clock edge)
    logic [W-1:0] m_s1, m_raw, m_st, m_st_d, m_mask, m_edge;
    logic         m_irq;
    logic [31:0]  m_rd;
    logic [W-1:0] m_hist[$];

    codebreaker_switch_pio #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(N),
        .EDGE_MODE(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write(write),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // A pin level is accepted once the synchronised input has shown the opposite
    // level for the last N cycles in a row; history restarts at reset.
    task automatic model_step(input logic r, input logic [W-1:0] p, input logic c,
                              input logic w, input logic [1:0] a, input logic [31:0] d);
        logic [W-1:0] n_raw, n_st, acc, rise, clr, sel;
        if (r) begin
            m_s1 = '0; m_raw = '0; m_st = '0; m_st_d = '0;
            m_mask = '0; m_edge = '0; m_irq = 1'b0; m_rd = '0;
            m_hist.delete();
            m_hist.push_back('0);
        end else begin
            n_raw = m_s1;
            if (DB_ON) begin
                acc = '0;
                if (m_hist.size() >= N) begin
                    acc = '1;
                    for (int j = 0; j < N; j++) acc &= m_hist[m_hist.size() - 1 - j] ^ m_st;
                end
                n_st = m_st ^ acc;
            end else begin
                n_st = n_raw;
            end
            rise = m_st & ~m_st_d;
            clr  = (c && w && a == 2'd3) ? d[W-1:0] : '0;
            case (a)
                2'd0: sel = m_st;
                2'd1: sel = m_mask;
                2'd2: sel = m_raw;
                default: sel = m_edge;
            endcase
            m_rd   = {22'd0, sel};
            m_irq  = |(m_edge & m_mask);
            m_edge = (m_edge & ~clr) | rise;
            if (c && w && a == 2'd1) m_mask = d[W-1:0];
            m_st_d = m_st;
            m_st   = n_st;
            m_raw  = n_raw;
            m_s1   = p;
            m_hist.push_back(n_raw);
            if (m_hist.size() > 16) void'(m_hist.pop_front());
        end
    endtask

    task automatic step(input logic r, input logic c, input logic w,
                        input logic [1:0] a, input logic [31:0] d);
        reset = r; in_port = pin_v; chipselect = c; write = w; address = a; writedata = d;
        @(posedge clk);
        model_step(r, pin_v, c, w, a, d);
        #1;
        check("readdata", readdata, m_rd);
        check("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b0, 1'b0, 1'b0, a, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, a, d);
    endtask

    initial begin
        int found;
        logic [1:0] ra;
        // 1: reset with all pins high
        pin_v = 10'h3FF;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        pin_v = '0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            check("post_reset_reg", readdata, 32'd0);
        end

        // 2: DATA latency
        for (int i = 0; i < 8; i++) rd(2'd0);
        pin_v = 10'h155;
        for (int i = 0; i < 10; i++) begin
            rd(2'd0);
            check("data_latency", readdata, (i >= LAT) ? 32'h155 : 32'h0);
        end
        rd(2'd2);
        check("raw_value", readdata, 32'h155);

        // 3: short glitch on bit0
        pin_v = '0;
        for (int i = 0; i < 10; i++) rd(2'd0);
        wr(2'd3, 32'hFFFF_FFFF);
        pin_v = 10'h001;
        for (int i = 0; i < 3; i++) rd(2'd0);
        pin_v = '0;
        for (int i = 0; i < 10; i++) rd(2'd0);
`ifdef CODEBREAKER_SWITCH_DEBOUNCE_EN
        check("glitch_data", readdata, 32'h0);
        rd(2'd3);
        check("glitch_edge", readdata, 32'h0);
`endif
        wr(2'd3, 32'h3FF);

        // 4: masked edge interrupt and W1C clear
        wr(2'd1, 32'h001);
        pin_v = 10'h001;
        for (int i = 0; i < 10; i++) rd(2'd3);
        check("edge_set", readdata, 32'h001);
        check("irq_set", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h001);
        rd(2'd3);
        check("edge_cleared", readdata, 32'h0);
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // 5: clear coinciding with a new bit3 edge
        pin_v = 10'h009;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            rd(2'd0);
            if (m_st[3] && !m_st_d[3]) found = 1;
        end
        check("bit3_edge_seen", 32'(found), 32'd1);
        wr(2'd3, 32'h008);
        rd(2'd3);
        check("set_beats_clear", {31'd0, readdata[3]}, 32'd1);

`ifndef CODEBREAKER_SWITCH_DEBOUNCE_EN
        // 6: no debounce, two-cycle latency
        pin_v = '0;
        wr(2'd3, 32'h3FF);
        for (int i = 0; i < 5; i++) rd(2'd0);
        pin_v = 10'h200;
        for (int i = 0; i < 4; i++) begin
            rd(2'd0);
            check("nodb_latency", readdata, (i >= 2) ? 32'h200 : 32'h0);
        end
`endif

        // randomized traffic with occasional mid-debounce resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) pin_v = W'($urandom);
            ra = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                step(1'b1, 1'b0, 1'b0, ra, 32'd0);
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), ra, $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
